// File: rtl/rr_merge_pkg.sv
// Shared types and constants for the two-input round-robin stream merger.
package rr_merge_pkg;

   typedef logic src_idx_t;

   localparam src_idx_t SRC0       = 1'b0;
   localparam src_idx_t SRC1       = 1'b1;
   // Pointer starts on SRC1 so the first tie after reset goes to SRC0
   localparam src_idx_t RESET_LAST = SRC1;

endpackage

// File: rtl/rr_merge_2_1_if.sv
// Handshake bundle for rr_merge_2_1: two valid/ready inputs, one registered output and the select.
interface rr_merge_2_1_if #(parameter int WIDTH = 8);
   import rr_merge_pkg::*;

   logic             in0_valid;
   logic             in0_ready;
   logic [WIDTH-1:0] in0_data;
   logic             in1_valid;
   logic             in1_ready;
   logic [WIDTH-1:0] in1_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   src_idx_t         out_src;
   src_idx_t         sel;

   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, out_ready,
      input  in0_ready, in1_ready, out_valid, out_data, out_src, sel
   );

   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
      output in0_ready, in1_ready, out_valid, out_data, out_src, sel
   );

endinterface

// File: rtl/rr_arb_2.sv
// Two-requester round-robin arbiter: combinational grant plus the last-winner pointer.
module rr_arb_2
   import rr_merge_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     req0,
   input  logic     req1,
   input  logic     advance,
   output src_idx_t grant,
   output src_idx_t last
);

   always_comb begin
      grant = last;
      unique case ({req1, req0})
         2'b01:   grant = SRC0;
         2'b10:   grant = SRC1;
         2'b11:   grant = ~last;
         default: grant = last;
      endcase
   end

   // Pointer moves only on a real transfer so idle or stalled cycles leave fairness untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last <= RESET_LAST;
      else if (advance)
         last <= grant;
   end

endmodule

// File: rtl/rr_merge_2_1.sv
// Round-robin 2:1 stream merge with a single registered output stage and exported source index.
module rr_merge_2_1
   import rr_merge_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic          clk,
   input  logic          rst_n,
   rr_merge_2_1_if.slave bus
);

   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;

   logic             occ;
   logic             accept;
   logic             xfer;
   src_idx_t         sel;
   src_idx_t         last_ptr_unused;
   logic [WIDTH-1:0] data_q;
   src_idx_t         src_q;

   rr_arb_2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req0    (bus.in0_valid),
      .req1    (bus.in1_valid),
      .advance (xfer),
      .grant   (sel),
      .last    (last_ptr_unused)
   );

   // Register can take a word when empty or when its current word leaves this cycle
   assign accept        = (occ == EMPTY) | bus.out_ready;
   assign bus.in0_ready = accept & (sel == SRC0);
   assign bus.in1_ready = accept & (sel == SRC1);
   assign xfer          = (bus.in0_valid & bus.in0_ready) | (bus.in1_valid & bus.in1_ready);

   assign bus.sel       = sel;
   assign bus.out_valid = (occ == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;

   // A reload takes priority over a drain, so simultaneous drain and transfer leaves no bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ    <= EMPTY;
         data_q <= '0;
         src_q  <= SRC0;
      end else if (xfer) begin
         occ    <= FULL;
         data_q <= (sel == SRC1) ? bus.in1_data : bus.in0_data;
         src_q  <= sel;
      end else if ((occ == FULL) && bus.out_ready) begin
         occ    <= EMPTY;
      end
   end

endmodule

// File: tb/tb_rr_merge_2_1.sv
// Randomized self-checking bench for rr_merge_2_1 against a transaction-level reference model.
module tb_rr_merge_2_1;

   logic clk;
   logic rst_n;

   rr_merge_2_1_if #(.WIDTH(8)) bus ();

   rr_merge_2_1 #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: who won the last transfer, and what the output register holds
   int       ref_last_winner;
   bit       ref_full;
   bit [7:0] ref_data;
   int       ref_src;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      ref_last_winner = 1;
      ref_full        = 0;
      ref_data        = 8'h00;
      ref_src         = 0;
   endtask

   // One clock cycle: drive inputs after the falling edge, check, then advance the model
   task automatic applyStimulus(input bit v0, input bit v1, input bit [7:0] d0,
                                input bit [7:0] d1, input bit rdy);
      int  winner;
      bit  can_take;
      bit  moved;
      @(negedge clk);
      bus.in0_valid = v0;
      bus.in1_valid = v1;
      bus.in0_data  = d0;
      bus.in1_data  = d1;
      bus.out_ready = rdy;
      #1;
      if (v0 && v1)      winner = 1 - ref_last_winner;
      else if (v0)       winner = 0;
      else if (v1)       winner = 1;
      else               winner = ref_last_winner;
      can_take = !ref_full || rdy;
      checkOutput("sel",       32'(bus.sel),       32'(winner));
      checkOutput("in0_ready", 32'(bus.in0_ready), 32'(can_take && winner == 0));
      checkOutput("in1_ready", 32'(bus.in1_ready), 32'(can_take && winner == 1));
      checkOutput("out_valid", 32'(bus.out_valid), 32'(ref_full));
      checkOutput("out_data",  32'(bus.out_data),  32'(ref_data));
      checkOutput("out_src",   32'(bus.out_src),   32'(ref_src));
      moved = can_take && ((winner == 0 && v0) || (winner == 1 && v1));
      if (moved) begin
         ref_data        = (winner == 1) ? d1 : d0;
         ref_src         = winner;
         ref_full        = 1;
         ref_last_winner = winner;
      end else if (rdy) begin
         ref_full = 0;
      end
   endtask

   initial begin
      bus.in0_valid = 0;
      bus.in1_valid = 0;
      bus.in0_data  = '0;
      bus.in1_data  = '0;
      bus.out_ready = 0;
      rst_n         = 0;
      model_reset();
      #12;
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_out_data",  32'(bus.out_data),  32'd0);
      checkOutput("reset_out_src",   32'(bus.out_src),   32'd0);
      rst_n = 1;

      // Fairness: both valid, sink always ready, expect 0,1,0,1
      for (int i = 0; i < 5; i++)
         applyStimulus(1, 1, 8'hA0 + 8'(i), 8'hB0 + 8'(i), 1);
      // Single source on in1
      applyStimulus(0, 1, 8'h00, 8'h5A, 1);
      applyStimulus(0, 0, 8'h00, 8'h00, 1);
      // Stall with both valid, then release
      applyStimulus(1, 1, 8'h11, 8'h22, 1);
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 1, 8'h33, 8'h44, 0);
      applyStimulus(1, 1, 8'h55, 8'h66, 1);
      applyStimulus(1, 1, 8'h77, 8'h88, 1);
      // in0-only burst, idle gap, then tie
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 0, 8'hC0 + 8'(i), 8'h00, 1);
      applyStimulus(0, 0, 8'h00, 8'h00, 1);
      applyStimulus(0, 0, 8'h00, 8'h00, 0);
      applyStimulus(1, 1, 8'hD0, 8'hE0, 1);
      applyStimulus(1, 1, 8'hD1, 8'hE1, 1);

      // Asynchronous reset mid-cycle while full
      applyStimulus(1, 0, 8'h99, 8'h00, 0);
      applyStimulus(0, 0, 8'h00, 8'h00, 0);
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      checkOutput("async_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("async_out_data",  32'(bus.out_data),  32'd0);
      model_reset();
      #1;
      rst_n = 1;
      applyStimulus(1, 1, 8'hF0, 8'hF1, 1);
      applyStimulus(1, 1, 8'hF2, 8'hF3, 1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                       8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      applyStimulus(0, 0, 8'h00, 8'h00, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
